// File: rtl/coax_pkg.sv
// Shared coax definitions: word width, default buffer sizing and tx sequencer state encoding.
package coax_pkg;

    localparam int unsigned COAX_WORD_WIDTH    = 10;
    localparam int unsigned COAX_TX_DEPTH      = 16;
    localparam int unsigned COAX_START_TIMEOUT = 64;

    typedef logic [COAX_WORD_WIDTH-1:0] coax_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } tx_state_e;

endpackage

// File: rtl/coax_fifo.sv
// Single-clock circular FIFO with head-of-queue peek; reusable by the receive path.
module coax_fifo
    import coax_pkg::*;
#(
    parameter int unsigned DEPTH = COAX_TX_DEPTH,
    parameter int unsigned WIDTH = COAX_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             write_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A write while full is dropped even when a pop lands in the same cycle.
    always_comb begin
        push     = write_i && !full_o && !clear_i;
        pop      = pop_i && !empty_o && !clear_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/coax_tx_buffer.sv
// Transmit word buffer and load sequencer feeding the coax bit transmitter.
// Optional flush input enabled by defining COAX_TX_BUFFER_FLUSH_EN.
module coax_tx_buffer
    import coax_pkg::*;
#(
    parameter int unsigned DEPTH         = COAX_TX_DEPTH,
    parameter int unsigned START_TIMEOUT = COAX_START_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COAX_WORD_WIDTH-1:0] data,
    input  logic                       write,
`ifdef COAX_TX_BUFFER_FLUSH_EN
    input  logic                       flush,
`endif
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic                       overflow,
    output logic                       timeout,
    output logic                       tx_load,
    output logic [COAX_WORD_WIDTH-1:0] tx_data,
    input  logic                       tx_active
);

    localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);

    tx_state_e        state_q, state_d;
    coax_word_t       tx_data_q, tx_data_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;
    logic             pop;
    logic             flush_w;
    coax_word_t       head;

`ifdef COAX_TX_BUFFER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    coax_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COAX_WORD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush_w),
        .write_i (write),
        .data_i  (data),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // The head word is only popped once the transmitter has taken it (or given up on).
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q | (write & full & ~flush_w);
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !flush_w) begin
                    tx_data_d  = head;
                    wait_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wait_cnt_d = wait_cnt_q + TMO_W'(1);
                if (flush_w) begin
                    state_d = ST_IDLE;
                end else if (tx_active) begin
                    pop     = 1'b1;
                    state_d = ST_SEND;
                end else if (wait_cnt_q == TMO_W'(START_TIMEOUT - 1)) begin
                    pop       = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!tx_active) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            wait_cnt_q <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            wait_cnt_q <= wait_cnt_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_load  = (state_q == ST_LOAD);
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != ST_IDLE) || !empty;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_coax_tx_buffer.sv
// Self-checking bench for coax_tx_buffer: vector table, randomized traffic vs queue model, corner sequences.
module tb_coax_tx_buffer;
    import coax_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data;
    logic       write;
    logic       flush;
    logic       full, empty, busy, overflow, timeout, tx_load;
    logic [9:0] tx_data;
    logic       tx_active;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] words[$];

    coax_tx_buffer #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .write     (write),
`ifdef COAX_TX_BUFFER_FLUSH_EN
        .flush     (flush),
`endif
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow),
        .timeout   (timeout),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       wr;
        logic [9:0] d;
        logic       act;
        logic       full;
        logic       empty;
        logic       busy;
        logic       load;
        logic [9:0] txd;
    } vec_t;

    // Stream words[] through the DUT against a queue model and a simple transmitter model.
    task automatic run_traffic(input int frame_len, input int wpct, input int budget);
        logic [9:0] exp_q[$];
        logic [9:0] held;
        int  occ, widx, xm_phase, xm_cnt, gap;
        bit  load_prev, w, p, done;
        occ = 0; widx = 0; xm_phase = 0; xm_cnt = 0; gap = 2;
        load_prev = 0; done = 0; held = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            check("full", 32'(full), 32'(occ == DEPTH));
            check("empty", 32'(empty), 32'(occ == 0));
            if (occ > 0) check("busy_q", 32'(busy), 1);
            if (tx_load && !load_prev) begin
                check("load_gap", 32'(gap >= 2), 1);
                if (exp_q.size() == 0) check("spurious_load", 1, 0);
                else check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
                held = tx_data;
                gap  = 0;
            end else if (tx_load) begin
                check("tx_data_stable", 32'(tx_data), 32'(held));
            end
            if (!tx_load) gap++;
            load_prev = tx_load;
            if (widx == words.size() && exp_q.size() == 0 && xm_phase == 0 && !tx_active && !busy) begin
                done = 1;
                break;
            end
            if (xm_phase == 0 && tx_load) begin
                xm_cnt   = $urandom_range(0, 4);
                xm_phase = 1;
            end
            if (xm_phase == 1) begin
                if (xm_cnt == 0) begin
                    tx_active = 1'b1;
                    xm_cnt    = (frame_len > 0) ? frame_len : $urandom_range(1, 8);
                    xm_phase  = 2;
                end else xm_cnt--;
            end else if (xm_phase == 2) begin
                xm_cnt--;
                if (xm_cnt == 0) begin
                    tx_active = 1'b0;
                    xm_phase  = 0;
                end
            end
            w     = (widx < words.size()) && !full && ($urandom_range(0, 99) < wpct);
            write = w;
            data  = w ? words[widx] : 10'($urandom);
            if (w) begin
                exp_q.push_back(words[widx]);
                widx++;
            end
            p = tx_load && tx_active;
            step();
            if (w && occ < DEPTH) occ++;
            if (p) occ--;
        end
        write = 1'b0;
        check("traffic_done", 32'(done), 1);
        check("overflow_clear", 32'(overflow), 0);
        check("timeout_clear", 32'(timeout), 0);
    endtask

    initial begin
        vec_t vt[13];
        int   lc;
        bit   seen;

        vt[0]  = '{1'b1, 10'h2A5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000};
        vt[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h2A5};
        vt[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h2A5};
        vt[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h2A5};
        vt[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h2A5};
        vt[5]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h2A5};
        vt[6]  = '{1'b1, 10'h0C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h2A5};
        vt[7]  = '{1'b1, 10'h111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0C3};
        vt[8]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0C3};
        vt[9]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0C3};
        vt[10] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h111};
        vt[11] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h111};
        vt[12] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h111};

        reset = 1'b1; write = 1'b0; data = '0; tx_active = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_tx_load", 32'(tx_load), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        reset = 1'b0;
        step();

        foreach (vt[i]) begin
            write = vt[i].wr; data = vt[i].d; tx_active = vt[i].act;
            step();
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].empty));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            check($sformatf("vec%0d_load", i), 32'(tx_load), 32'(vt[i].load));
            check($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(vt[i].txd));
        end
        write = 1'b0; tx_active = 1'b0;

        words = {10'h001, 10'h3FF, 10'h155};
        run_traffic(100, 100, 600);
        words.delete();
        for (int i = 0; i < 40; i++) words.push_back(10'($urandom));
        run_traffic(0, 40, 3000);
        words.delete();
        for (int i = 0; i < 40; i++) words.push_back(10'($urandom));
        run_traffic(3, 100, 3000);

        // Stuck transmitter: fill, overflow, then start timeout.
        lc = 0;
        for (int i = 0; i < 17; i++) begin
            write = 1'b1; data = 10'(10'h100 + i);
            step();
            if (tx_load) lc++;
            if (i == 15) begin
                check("full_at_16", 32'(full), 1);
                check("no_ovf_at_16", 32'(overflow), 0);
            end
        end
        write = 1'b0;
        check("full_at_17", 32'(full), 1);
        check("ovf_at_17", 32'(overflow), 1);
        check("stuck_tx_data", 32'(tx_data), 32'h100);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_load) lc++;
            if (timeout) begin
                seen = 1;
                break;
            end
        end
        check("timeout_seen", 32'(seen), 1);
        check("load_cycles", 32'(lc), 32'(TMO));
        check("full_after_tmo", 32'(full), 0);
        check("load_after_tmo", 32'(tx_load), 0);
        step();
        check("next_load", 32'(tx_load), 1);
        check("next_word", 32'(tx_data), 32'h101);

        // Async reset mid-SEND with words still queued.
        tx_active = 1'b1;
        step();
        check("send_load_low", 32'(tx_load), 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_load", 32'(tx_load), 0);
        check("mid_rst_data", 32'(tx_data), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_full", 32'(full), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_tmo", 32'(timeout), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) tx_active = 1'b0;
            step();
            check("post_rst_no_load", 32'(tx_load), 0);
        end
        write = 1'b1; data = 10'h2C7;
        step();
        write = 1'b0;
        check("post_rst_load_wait", 32'(tx_load), 0);
        step();
        check("post_rst_load", 32'(tx_load), 1);
        check("post_rst_word", 32'(tx_data), 32'h2C7);
        tx_active = 1'b1;
        step();
        tx_active = 1'b0;
        step();
        check("post_rst_idle", 32'(busy), 0);

`ifdef COAX_TX_BUFFER_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            write = 1'b1; data = 10'(10'h050 + i);
            step();
        end
        write = 1'b0;
        check("flush_pre_load", 32'(tx_load), 1);
        flush = 1'b1;
        write = 1'b1; data = 10'h3C3;
        step();
        flush = 1'b0; write = 1'b0;
        check("flush_load", 32'(tx_load), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("flush_no_load", 32'(tx_load), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coax_tx_buffer.md
Name: coax_tx_buffer

Overview:
Transmit-side word buffer and sequencer that sits directly upstream of the coax bit transmitter. Host logic pushes 10-bit coax words into a small FIFO. The sequencer presents each word to the transmitter with a load pulse, then waits for that frame to finish before presenting the next word. It hides the transmitter's one-word-at-a-time, rising-edge load protocol from the host and reports overflow and transmitter stall.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
START_TIMEOUT, 64, clocks allowed in LOAD for tx_active to rise before the word is abandoned.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
data  input  10  word to enqueue
write  input  1  enqueue strobe; one word per cycle while high
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
busy  output  1  high when state != IDLE or FIFO not empty
overflow  output  1  sticky; write attempted while full
timeout  output  1  sticky; transmitter failed to start within START_TIMEOUT
tx_load  output  1  load strobe to transmitter
tx_data  output  10  word presented to transmitter
tx_active  input  1  transmitter active indication

Behaviour:
- Interface fixed: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: FIFO empty, pointers 0, state IDLE, tx_load=0, tx_data=0, full=0, empty=1, busy=0, overflow=0, timeout=0.
- FIFO storage:
  - Circular buffer with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - Count is clog2(DEPTH)+1 bits.
  - full and empty are decoded from count after the clock edge, with no lookahead.
- Write rules:
  - A write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle when not full leave count unchanged.
- State machine: IDLE, LOAD, SEND.
- IDLE:
  - If !empty, capture the head word into tx_data and go to LOAD.
  - The word stays in the FIFO at this point.
- LOAD:
  - tx_load=1, decoded from state, glitch-free because state is registered.
  - A start-wait counter increments each cycle.
  - If tx_active=1: pop the head and go to SEND.
  - Else if the counter reaches START_TIMEOUT-1: pop and discard the head, set timeout, go to IDLE.
- SEND:
  - tx_load=0, which guarantees a low phase before the next rising edge.
  - When tx_active=0, go to IDLE.
- Latency:
  - A write sampled at edge N asserts tx_load from edge N+1 with tx_data valid in the same cycle.
  - Back-to-back frames: the cycle after tx_active falls, state is IDLE; tx_load rises one edge later.
  - So there are at least 2 clocks of load-low between frames.
- tx_data:
  - Held constant from IDLE->LOAD until the next IDLE->LOAD capture.
  - Never changes while tx_load=1.
- Reset mid-operation:
  - All state clears immediately and the FIFO contents are discarded.
  - The transmitter may still finish its current frame; after reset the sequencer starts in IDLE and ignores tx_active until its next LOAD.
- Sticky flags are cleared only by reset.

Optional Feature:
COAX_TX_BUFFER_FLUSH_EN.
- Defined: adds input flush (1 bit). When flush=1 for one cycle, the FIFO is emptied and a write in the same cycle is ignored. If state is LOAD, the sequencer returns to IDLE; if state is SEND, it completes normally. overflow and timeout are unaffected.
- Undefined: no flush port; the FIFO is cleared only by reset.

Decomposition:
- Shared package coax_pkg: COAX_WORD_WIDTH=10, state encodings, DEPTH default.
- One natural sub-module: coax_fifo, a synchronous single-clock FIFO with write/pop/full/empty/head. It is reusable by the receive path.
- The sequencer stays in coax_tx_buffer.

Test Plan:
- Single word: write 10'h2A5 at cycle 5 -> tx_load=1 from cycle 6 with tx_data=10'h2A5; model tx_active high at cycle 8 -> tx_load=0 at cycle 9; empty=1 from cycle 9.
- Burst: write 3 words (10'h001, 10'h3FF, 10'h155) on consecutive cycles; transmitter model runs 100-clock frames -> three frames in order, ≥2 clocks of tx_load low between them, busy falls after the last tx_active falls.
- Full/overflow at DEPTH=16 with tx_active held 0 by the stuck model:
  - Write 17 words -> full=1 after the 16th, overflow=1 after the 17th.
  - After 64 LOAD clocks, timeout=1 and count=15.
- Wrap-around: 40 words through a DEPTH=4 buffer with write throttled on full -> all 40 emitted in order, no overflow.
- Async reset asserted mid-SEND with 5 words queued -> outputs at reset values within the same cycle; no tx_load after release until a new write.
- (FLUSH_EN) flush during LOAD with 3 queued -> tx_load drops the next cycle, empty=1, no frame started.
